nibble_join_8b: RTL
===================

Name: nibble_join_8b

Overview:
- Sequential inverse of the team's 8b-to-nibble split block: accepts a stream of 4-bit nibbles and packs each pair into one 8-bit byte.
- Input side and output side each use a latency-insensitive val/rdy handshake.
- Used at the receive end of nibble-wide links to rebuild bytes before downstream byte-oriented logic.
- One-entry output buffer plus a one-nibble holding register; sustains one byte every two cycles.

Parameters:
- LO_FIRST, 1, 1: first accepted nibble of a pair becomes byte[3:0] and second becomes byte[7:4]; 0: first nibble becomes byte[7:4] and second becomes byte[3:0].

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_val  input  1  upstream nibble valid
- in_rdy  output  1  block can accept a nibble this cycle
- in_  input  4  nibble data
- out_val  output  1  assembled byte valid
- out_rdy  input  1  downstream can accept byte this cycle
- out  output  8  assembled byte

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (port reset). Reset sampled on the rising edge of clk.
- Transfers: an input transfer occurs on a rising edge with in_val && in_rdy. An output transfer occurs on a rising edge with out_val && out_rdy.
- States:
  - EMPTY: no nibble held, no byte pending.
  - HALF: first nibble held.
  - FULL: byte pending on out.
- Transitions:
  - EMPTY + in xfer -> HALF; capture in_ as first nibble.
  - HALF + in xfer -> FULL; byte = combine(held, in_) per LO_FIRST.
  - HALF without in xfer -> HALF; nibble retained indefinitely.
  - FULL + out xfer, no in xfer -> EMPTY.
  - FULL + out xfer + in xfer in the same cycle -> HALF; the new nibble is captured as first nibble, giving zero-bubble pipelining.
  - FULL without out xfer -> FULL; out stable.
- Handshake outputs:
  - in_rdy = (state != FULL) || out_rdy. Purely combinational from state and out_rdy; no dependence on in_val.
  - out_val = (state == FULL). Registered; does not depend on in_val or out_rdy.
  - out must hold its value while out_val=1 and out_rdy=0.
- Latency: the byte appears on out the cycle after the second nibble is accepted. Throughput is one byte per 2 cycles with continuous in_val and out_rdy.
- Reset values:
  - state=EMPTY, in_rdy=1, out_val=0, out=8'h00, held nibble=4'h0.
  - Reset mid-pair discards the held nibble.
  - Reset while FULL drops the pending byte.
- Don't-cares: in_ is ignored when in_val=0. out_rdy is ignored when out_val=0, except in the in_rdy equation.

Optional Feature:
- Macro NIBBLE_JOIN_8B_PARITY_EN.
- When defined: adds output port out_par (1 bit), the even parity (XOR reduction) of the assembled byte.
  - Registered together with out.
  - Valid when out_val=1; held stable under backpressure.
  - Reset value 0.
- When undefined: port absent; all other behaviour identical.

Test Plan:
- Reset then nibbles 4'h3, 4'h2 with out_rdy=1 (LO_FIRST=1) -> out_val=1 with out=8'h23 one cycle after the second accept, and in_rdy=1 throughout.
- Same sequence with LO_FIRST=0 -> out=8'h32.
- Backpressure: byte 8'hab pending, out_rdy=0 for 3 cycles, in_val=1 in_=4'hc -> in_rdy=0, out stays 8'hab, out_val stays 1. Raise out_rdy -> ab consumed, nibble c accepted in the same cycle, state HALF.
- Streaming: 20 random nibbles with continuous in_val=1, out_rdy=1 -> 10 bytes matching a pairwise reference model, one byte every 2 cycles, no bubbles beyond that.
- Reset mid-pair: accept 4'h5, assert reset, then send 4'h7, 4'h1 -> out=8'h17, proving 5 was discarded. After reset, out_val=0 and out=8'h00.
- Parity (macro defined): bytes 8'h00, 8'h01, 8'hff, 8'h80 -> out_par = 0, 1, 0, 1.

Source files
------------

// File: rtl/nibble_join_8b.sv
// nibble_join_8b: packs pairs of val/rdy nibbles into val/rdy bytes; optional out_par via NIBBLE_JOIN_8B_PARITY_EN.
module nibble_join_8b #(
  parameter bit LO_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [3:0] in_,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [7:0] out
`ifdef NIBBLE_JOIN_8B_PARITY_EN
  ,
  output logic       out_par
`endif
);
  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
  state_t state_q, state_d;
  logic [3:0] nib_q, nib_d;
  logic [7:0] byte_q, byte_d;
  logic in_xfer, out_xfer;
  always_comb begin
    in_rdy   = (state_q != FULL) || out_rdy;
    out_val  = state_q == FULL;
    in_xfer  = in_val && in_rdy;
    out_xfer = out_val && out_rdy;
    state_d  = state_q == EMPTY ? (in_xfer ? HALF : EMPTY) :
               state_q == HALF  ? (in_xfer ? FULL : HALF) :
               out_xfer         ? (in_xfer ? HALF : EMPTY) : FULL;
    // any accept outside HALF starts a new pair, including the FULL pass-through case
    nib_d    = (in_xfer && state_q != HALF) ? in_ : nib_q;
    byte_d   = (in_xfer && state_q == HALF) ? (LO_FIRST ? {in_, nib_q} : {nib_q, in_}) : byte_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      nib_q   <= 4'h0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      byte_q  <= byte_d;
    end
  end
  assign out = byte_q;
`ifdef NIBBLE_JOIN_8B_PARITY_EN
  logic par_q;
  always_ff @(posedge clk) begin
    if (reset) par_q <= 1'b0;
    else par_q <= ^byte_d;
  end
  assign out_par = par_q;
`endif
endmodule
